// File: rtl/board_pkg.sv
// board_pkg: shared cell codes, colours and addressing for the board renderer
package board_pkg;
  typedef enum logic [1:0] {WATER = 2'b00, SHIP = 2'b01, HIT = 2'b10, MISS = 2'b11} cell_code_t;
  localparam int BOARD_DIM = 8;
  localparam int ROW_LSB = 3;
  localparam int COL_LSB = 0;
  localparam logic [11:0] C_GRID = 12'h000;
  localparam logic [11:0] C_HIT = 12'hF00;
  localparam logic [11:0] C_MISS = 12'hFFF;
  localparam logic [11:0] C_SHIP = 12'h888;
  localparam logic [11:0] C_WATER = 12'h03F;
endpackage

// File: rtl/board_draw_delay_line.sv
// delay_line: resettable register chain used to keep bypassed signals aligned with the pipeline
module delay_line #(
  parameter int WIDTH = 1,
  parameter int CLK_DEL = 1
) (
  input logic clk,
  input logic rst,
  input logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [CLK_DEL];
  // shift the input one stage per clock
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < CLK_DEL; i++) stage[i] <= stage[i-1];
    end
  end
  assign q = stage[CLK_DEL-1];
endmodule

// File: rtl/board_draw.sv
// board_draw: scans both boards with the raster, paints cell codes and counts hits per frame
module board_draw
  import board_pkg::*;
#(
  parameter int CELL_SIZE = 32,
  parameter int HOST_X = 64,
  parameter int GUEST_X = 384,
  parameter int BOARD_Y = 112,
  parameter int SHIPS_TOTAL = 4
) (
  input logic clk,
  input logic rst,
  input logic [10:0] hcount_in,
  input logic [10:0] vcount_in,
  input logic hsync_in,
  input logic vsync_in,
  input logic hblnk_in,
  input logic vblnk_in,
  input logic [11:0] rgb_in,
  output logic [5:0] ship_xy_host,
  output logic [5:0] ship_xy_guest,
  input logic [1:0] ship_code_host,
  input logic [1:0] ship_code_guest,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic hsync_out,
  output logic vsync_out,
  output logic hblnk_out,
  output logic vblnk_out,
  output logic [11:0] rgb_out,
  output logic [2:0] hits_host,
  output logic [2:0] hits_guest,
  output logic host_sunk,
  output logic guest_sunk
);
  localparam int CELL_LOG2 = $clog2(CELL_SIZE);
  localparam int SPAN = BOARD_DIM * CELL_SIZE;
  localparam logic [10:0] HX0 = 11'(HOST_X);
  localparam logic [10:0] HX1 = 11'(HOST_X + SPAN);
  localparam logic [10:0] GX0 = 11'(GUEST_X);
  localparam logic [10:0] GX1 = 11'(GUEST_X + SPAN);
  localparam logic [10:0] BY0 = 11'(BOARD_Y);
  localparam logic [10:0] BY1 = 11'(BOARD_Y + SPAN);
  localparam logic [CELL_LOG2-1:0] HALF = {1'b1, {(CELL_LOG2-1){1'b0}}};
  localparam logic [2:0] SINK = 3'(SHIPS_TOTAL);
  logic in_v, in_h, in_g, grid, centre;
  logic [10:0] lx_h, lx_g, lx, ly;
  logic in_h1, in_g1, grid1, centre1;
  logic in_h2, in_g2, grid2, centre2;
  cell_code_t code_h2, code_g2, code;
  logic [11:0] rgb_d2, rgb_c;
  logic vs_prev, frame_end, cnt_h_ev, cnt_g_ev;
  logic [2:0] cnt_h, cnt_g;
  // region test and per-cell geometry for the current raster position
  always_comb begin
    in_v = vcount_in >= BY0 && vcount_in < BY1;
    in_h = in_v && hcount_in >= HX0 && hcount_in < HX1;
    in_g = in_v && hcount_in >= GX0 && hcount_in < GX1;
    lx_h = hcount_in - HX0;
    lx_g = hcount_in - GX0;
    ly = vcount_in - BY0;
    lx = in_h ? lx_h : lx_g;
    grid = lx[CELL_LOG2-1:0] == '0 || ly[CELL_LOG2-1:0] == '0;
    centre = lx[CELL_LOG2-1:0] == HALF && ly[CELL_LOG2-1:0] == HALF;
  end
  // S1 address/flag register and S2 code/flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      ship_xy_host <= '0;
      ship_xy_guest <= '0;
      {in_h1, in_g1, grid1, centre1} <= '0;
      {in_h2, in_g2, grid2, centre2} <= '0;
      code_h2 <= WATER;
      code_g2 <= WATER;
    end else begin
      if (in_h) ship_xy_host <= {ly[CELL_LOG2+2:CELL_LOG2], lx_h[CELL_LOG2+2:CELL_LOG2]};
      if (in_g) ship_xy_guest <= {ly[CELL_LOG2+2:CELL_LOG2], lx_g[CELL_LOG2+2:CELL_LOG2]};
      {in_h1, in_g1, grid1, centre1} <= {in_h, in_g, grid, centre};
      {in_h2, in_g2, grid2, centre2} <= {in_h1, in_g1, grid1, centre1};
      code_h2 <= cell_code_t'(ship_code_host);
      code_g2 <= cell_code_t'(ship_code_guest);
    end
  end
  delay_line #(.WIDTH(26), .CLK_DEL(3)) u_timing (
    .clk(clk), .rst(rst),
    .d({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in}),
    .q({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out})
  );
  delay_line #(.WIDTH(12), .CLK_DEL(2)) u_rgb (.clk(clk), .rst(rst), .d(rgb_in), .q(rgb_d2));
  // colour priority: background outside boards, then grid, hit, miss, host ship, water
  always_comb begin
    code = in_h2 ? code_h2 : code_g2;
    rgb_c = !(in_h2 || in_g2) ? rgb_d2 :
            grid2 ? C_GRID :
            code == HIT ? C_HIT :
            code == MISS ? C_MISS :
            (code == SHIP && in_h2) ? C_SHIP : C_WATER;
    frame_end = vsync_out && !vs_prev;
    cnt_h_ev = centre2 && in_h2 && code_h2 == HIT;
    cnt_g_ev = centre2 && in_g2 && code_g2 == HIT;
  end
  // S3 pixel register, per-frame hit counters and frame-end latching
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_out <= '0;
      vs_prev <= 1'b0;
      {cnt_h, cnt_g, hits_host, hits_guest} <= '0;
      {host_sunk, guest_sunk} <= '0;
    end else begin
      rgb_out <= rgb_c;
      vs_prev <= vsync_out;
      if (frame_end) begin
        hits_host <= cnt_h;
        hits_guest <= cnt_g;
        host_sunk <= cnt_h >= SINK;
        guest_sunk <= cnt_g >= SINK;
        cnt_h <= '0;
        cnt_g <= '0;
      end else begin
        if (cnt_h_ev && cnt_h != 3'd7) cnt_h <= cnt_h + 3'd1;
        if (cnt_g_ev && cnt_g != 3'd7) cnt_g <= cnt_g + 3'd1;
      end
    end
  end
endmodule
